// File: rtl/alu_pkg.sv
// alu_pkg: operation encoding shared by the ALU decoder and the add/subtract unit.
//   op_t            2-bit ALU add/sub operation code
//   op_is_sub()     operation subtracts (B is inverted, carry-in forced to 1)
//   op_is_signed()  operation reports signed overflow
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDU = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBU = 2'b11
    } op_t;

    function automatic logic op_is_sub(input op_t op);
        return (op == OP_SUB) || (op == OP_SUBU);
    endfunction

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: one SW-bit slice of the pipelined carry chain plus its stage register.
// Slice IDX adds bits [IDX*SW +: SW] of a_i and b_i with cin_i and writes them into the
// running partial sum. Operands, op and partial sum travel full-width; bits no later
// stage reads have no loads.
//   clk_i, rst_ni    clock, synchronous active-low reset
//   valid_i          upstream beat valid (taken when this stage can accept)
//   ready_i          downstream takes this stage's content this cycle
//   a_i, b_i         operand A and conditioned operand B'
//   sum_i, cin_i     partial sum of lower slices, carry into this slice
//   op_i             operation travelling with the beat
//   valid_o          stage holds a beat
//   a_o, b_o, sum_o  registered operands and partial sum
//   cout_o, op_o     registered carry-out of this slice and op
module addsub_seg
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 16,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cin_i,
    input  op_t              op_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output op_t              op_o
);

    localparam int unsigned LSB = IDX * SW;

    logic             valid_q;
    logic             load;
    logic [SW:0]      slice;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    op_t              op_q;

    // Accept when empty or when the current content leaves this cycle.
    assign load  = valid_i & (~valid_q | ready_i);
    assign slice = {1'b0, a_i[LSB +: SW]} + {1'b0, b_i[LSB +: SW]} + {{SW{1'b0}}, cin_i};

    always_comb begin
        sum_d             = sum_i;
        sum_d[LSB +: SW]  = slice[SW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            op_q    <= OP_ADD;
        end else begin
            if (load) begin
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            // Data only changes on load, so a blocked stage holds its beat unchanged.
            if (load) begin
                a_q    <= a_i;
                b_q    <= b_i;
                sum_q  <= sum_d;
                cout_q <= slice[SW];
                op_q   <= op_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign op_o    = op_q;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined signed/unsigned add/subtract with MIPS overflow semantics.
// The carry chain is split into SEGS slices of WIDTH/SEGS bits, one pipeline stage each,
// with a valid/ready handshake and full backpressure.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  operand beat handshake (in_ready may depend on out_ready)
//   op                  00 ADD, 01 ADDU, 10 SUB, 11 SUBU
//   in1, in2            operands A and B
//   out_valid, out_ready result beat handshake
//   result              A+B or A-B modulo 2^WIDTH
//   carry               carry-out of the top bit (for subtraction: 1 = no borrow)
//   overflow            signed overflow, ADD/SUB only
//   zero                result is zero (only asserted with out_valid)
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEGS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW = WIDTH / SEGS;

    // Index k is the input of stage k; index SEGS is the last stage's register.
    logic             v_s   [SEGS+1];
    logic             rdy   [SEGS+1];
    logic [WIDTH-1:0] a_s   [SEGS+1];
    logic [WIDTH-1:0] b_s   [SEGS+1];
    logic [WIDTH-1:0] sum_s [SEGS+1];
    logic             c_s   [SEGS+1];
    op_t              op_s  [SEGS+1];

    op_t  op_in;
    logic sub;
    logic a_msb;
    logic b_msb;
    logic unused_ab;

    assign op_in = op_t'(op);
    assign sub   = op_is_sub(op_in);

    // Subtraction is A + ~B + 1.
    assign v_s[0]   = in_valid;
    assign a_s[0]   = in1;
    assign b_s[0]   = sub ? ~in2 : in2;
    assign sum_s[0] = '0;
    assign c_s[0]   = sub;
    assign op_s[0]  = op_in;

    // rdy[k]: stage k can take a beat; a full stage frees up when everything below drains.
    always_comb begin
        for (int k = 0; k <= SEGS; k++) begin
            rdy[k] = 1'b0;
        end
        rdy[SEGS] = out_ready;
        for (int k = SEGS - 1; k >= 0; k--) begin
            rdy[k] = ~v_s[k+1] | rdy[k+1];
        end
    end

    assign in_ready = rst_n & rdy[0];

    for (genvar k = 0; k < SEGS; k++) begin : g_seg
        addsub_seg #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .IDX   (k)
        ) u_seg (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (v_s[k]),
            .ready_i (rdy[k+1]),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .sum_i   (sum_s[k]),
            .cin_i   (c_s[k]),
            .op_i    (op_s[k]),
            .valid_o (v_s[k+1]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .sum_o   (sum_s[k+1]),
            .cout_o  (c_s[k+1]),
            .op_o    (op_s[k+1])
        );
    end

    assign a_msb     = a_s[SEGS][WIDTH-1];
    assign b_msb     = b_s[SEGS][WIDTH-1];
    // Only the operand sign bits are needed past the adder.
    assign unused_ab = ^{a_s[SEGS][WIDTH-2:0], b_s[SEGS][WIDTH-2:0]};

    assign out_valid = v_s[SEGS];
    assign result    = sum_s[SEGS];
    assign carry     = c_s[SEGS];
    assign overflow  = op_is_signed(op_s[SEGS]) & (a_msb == b_msb) & (result[WIDTH-1] != a_msb);
    // Gated with valid so the idle/reset value is 0 rather than "result is zero".
    assign zero      = v_s[SEGS] & (result == '0);

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int S = 2;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    bit   hold_q = 1'b0;
    exp_t held;
    bit   rand_done = 1'b0;

    addsub_pipe #(
        .WIDTH (W),
        .SEGS  (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operand values.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t     e;
        longint   sa, sb, sr, lim;
        logic [W:0] wide;
        bit       is_sub, is_sgn;
        is_sub = (o == OP_SUB) || (o == OP_SUBU);
        is_sgn = (o == OP_ADD) || (o == OP_SUB);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) << (W - 1);
        if (is_sub) begin
            e.res = a - b;
            e.c   = (a >= b);
            sr    = sa - sb;
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            e.res = wide[W-1:0];
            e.c   = wide[W];
            sr    = sa + sb;
        end
        e.ov = is_sgn && (sr >= lim || sr < -lim);
        e.z  = (e.res == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] sp [5];
        sp[0] = '0;
        sp[1] = 32'h1;
        sp[2] = 32'h7FFF_FFFF;
        sp[3] = 32'h8000_0000;
        sp[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Scoreboard and output-hold monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", out_valid, 1);
                check("hold_res", result, held.res);
                check("hold_flags", {carry, overflow, zero}, {held.c, held.ov, held.z});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("res", result, e.res);
                    check("carry", carry, e.c);
                    check("overflow", overflow, e.ov);
                    check("zero", zero, e.z);
                end
            end
            if (in_valid && in_ready) q.push_back(model(op, in1, in2));
            hold_q = out_valid && !out_ready;
            held   = '{res: result, c: carry, ov: overflow, z: zero};
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept", acc, 1);
    endtask

    task automatic dir(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r, input bit c,
                       input bit ov, input bit z);
        out_ready = 1'b1;
        send(o, a, b);
        for (int i = 0; i < S - 1; i++) begin
            @(negedge clk);
            check({tag, "_lat_early"}, out_valid, 0);
        end
        @(negedge clk);
        check({tag, "_lat_valid"}, out_valid, 1);
        check({tag, "_res"}, result, r);
        check({tag, "_carry"}, carry, c);
        check({tag, "_ovf"}, overflow, ov);
        check({tag, "_zero"}, zero, z);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carry, overflow, zero}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed arithmetic
        dir("add_neg", OP_ADD, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'hFFFF_FFF4, 1, 0, 0);
        dir("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0);
        dir("addu_noovf", OP_ADDU, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 0);
        dir("sub_borrow", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
        dir("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1, 0);
        dir("add_min_min", OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 1, 1);

        // Backpressure: pipe fills after S beats and holds its output
        out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd2);
        send(OP_SUB, 32'd10, 32'd3);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_first", result, 32'd3);
        repeat (3) @(negedge clk);
        check("bp_hold_res", result, 32'd3);
        check("bp_in_ready_hold", in_ready, 0);
        @(posedge clk);
        #1;
        fork
            begin
                send(OP_ADDU, 32'hFFFF_FFFF, 32'd1);
                send(OP_SUBU, 32'd0, 32'd1);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_drain_gap", out_valid, 1);
                end
            end
        join
        @(posedge clk);
        #1;

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(OP_ADD, 32'd100, 32'd200);
        send(OP_SUB, 32'd1, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_flags", {carry, overflow, zero}, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dir("post_rst", OP_SUBU, 32'd3, 32'd3, 32'd0, 1, 0, 1);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(2'($urandom_range(0, 3)), rnd(), rnd());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined integer add/subtract unit for the MIPS datapath ALU. It generalises the 32-bit combinational signed adder into a configurable unit:
- operand width is a parameter;
- the carry chain is split across a configurable number of pipeline stages;
- it performs signed and unsigned add/subtract with MIPS overflow semantics;
- it produces carry, overflow and zero flags;
- it uses a valid/ready handshake with full backpressure.

## Interface
- WIDTH, 32: operand/result width in bits.
- SEGS, 2: number of carry-chain segments and pipeline stages. WIDTH % SEGS must be 0. SEGS ≥ 1.

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- op  input  2  00 ADD, 01 ADDU, 10 SUB, 11 SUBU
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  A+B or A−B, modulo 2^WIDTH
- carry  output  1  unsigned carry-out of the final bit; for SUB/SUBU, 1 means no borrow
- overflow  output  1  signed overflow; ADD and SUB only, 0 for ADDU/SUBU
- zero  output  1  result == 0

## Operation
- Segment width is SW = WIDTH/SEGS.
- SUB/SUBU:
  - B' = ~in2.
  - Carry-in to segment 0 is 1.
- ADD/ADDU:
  - B' = in2.
  - Carry-in is 0.
- Stage k (k = 0..SEGS−1) computes bits [k·SW +: SW] from A, B' and the registered carry of stage k−1.
- Each stage registers:
  - its partial sum;
  - the unconsumed upper operand slices;
  - op;
  - the A and B' MSBs;
  - its carry-out.
- overflow = signed_op & (A_msb == B'_msb) & (result_msb != A_msb). It is evaluated in the last stage.
- The result always wraps. The unit only flags overflow; trap generation belongs to the control path.
- zero is computed from the full registered result in the last stage.
- Each stage holds a valid bit.
  - Stage k loads when it is empty, or when its content moves on this cycle.
  - Stage SEGS−1 moves on when out_valid & out_ready.
  - A stage holds its content, unchanged, while it is full and downstream is blocked.
- in_ready = rst_n & (!v0 | stage 0 advancing). The combinational out_ready→in_ready path is permitted.
- A beat is accepted when in_valid & in_ready.
- out_valid = v[SEGS−1]. result, carry, overflow and zero are driven from the last stage's registers.
- While out_valid & !out_ready, result and all flags are held stable.
- Beats are never dropped, duplicated or reordered.

## Timing
- Reset, while rst_n is low at a clock edge:
  - all stage valid bits clear to 0;
  - result, carry, overflow and zero clear to 0;
  - out_valid is 0;
  - in_ready is 0 while rst_n is low.
- Reset mid-operation discards all in-flight beats. out_valid is 0 on the cycle after the reset edge.
- Latency: a beat accepted at edge n is presented with out_valid = 1 after edge n+SEGS−1 (SEGS edges including acceptance), when there is no backpressure.
- Throughput: one beat per cycle while out_ready stays high.
- Simultaneous accept and drain with the pipe full: the accept succeeds in the same cycle, with no bubble.
- Backpressure: with out_ready low, the pipe fills after SEGS beats. in_ready then drops to 0 in that same cycle.
- SEGS = 1: the unit degenerates to a single registered adder with 1-cycle latency.

## Structure
- Shared package alu_pkg holds:
  - op encoding constants OP_ADD, OP_ADDU, OP_SUB, OP_SUBU;
  - the op typedef.
  The main ALU decoder reuses these.
- Sub-module addsub_seg: one SW-bit add slice plus its pipeline register and valid/handshake logic. It is instantiated SEGS times through a generate loop. addsub_pipe adds only the input B'/carry-in conditioning and the last-stage flag logic.

## Test plan
- WIDTH = 32, SEGS = 2, out_ready = 1:
  - ADD −5 + −7 → result 0xFFFFFFF4, carry 1, overflow 0, zero 0.
  - The result appears 2 edges after acceptance.
- ADD 0x7FFFFFFF + 1 → 0x80000000, overflow 1. The same operands with ADDU → 0x80000000, overflow 0.
- SUB 5 − 7 → 0xFFFFFFFE, carry 0, overflow 0. SUB 0x80000000 − 1 → 0x7FFFFFFF, overflow 1, carry 1.
- ADD 0x80000000 + 0x80000000 → result 0, carry 1, overflow 1, zero 1.
- Backpressure:
  - Stream 4 beats with out_ready held 0.
  - in_ready must fall after 2 accepts.
  - Outputs must be held stable.
  - Raising out_ready must drain all 4 beats in order, with no gaps.
- Reset mid-operation: drive rst_n low with 2 beats in flight. The next cycle shows out_valid 0 and all outputs 0. After release, the first new beat emerges with normal latency.
